// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I sequencing controller.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_LUI, CLS_AUIPC, CLS_CSR
  } class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SR   = 4'b1000;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_READ = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;
  localparam logic [1:0] RES_CSR  = 2'b11;

  localparam logic [1:0] RWS_RESULT = 2'b00;
  localparam logic [1:0] RWS_IMM    = 2'b01;
  localparam logic [1:0] RWS_PCIMM  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef struct packed {
    logic [1:0] result_src;
    logic [1:0] reg_write_src;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic       arithm_log;
    logic       alu_src;
    logic       br_invert;
    class_t     cls;
    logic       legal;
  } dec_t;

  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SR;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: datapath selects, instruction class and legality.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;

  assign op = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    dec_o = '0;
    dec_o.cls = CLS_ALU;
    case (op)
      OP_R: begin
        dec_o.legal       = (f7 == 7'b0) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
        dec_o.alu_control = (f3 == 3'b000 && f7[5]) ? ALU_SUB : alu_from_f3(f3);
        dec_o.arithm_log  = f7[5];
      end
      OP_I: begin
        dec_o.legal       = (f3 == 3'b001) ? (f7 == 7'b0) :
                            (f3 == 3'b101) ? (f7 == 7'b0 || f7 == 7'b0100000) : 1'b1;
        dec_o.alu_control = alu_from_f3(f3);
        dec_o.arithm_log  = (f3 == 3'b101) && f7[5];
        dec_o.alu_src     = 1'b1;
        dec_o.imm_src     = IMM_I;
      end
      OP_LOAD: begin
        dec_o.legal      = (f3 == 3'b010);
        dec_o.cls        = CLS_LOAD;
        dec_o.alu_src    = 1'b1;
        dec_o.imm_src    = IMM_I;
        dec_o.result_src = RES_READ;
      end
      OP_STORE: begin
        dec_o.legal   = (f3 == 3'b010);
        dec_o.cls     = CLS_STORE;
        dec_o.alu_src = 1'b1;
        dec_o.imm_src = IMM_S;
      end
      OP_BRANCH: begin
        dec_o.legal       = (f3[2:1] != 2'b01);
        dec_o.cls         = CLS_BRANCH;
        dec_o.imm_src     = IMM_B;
        dec_o.alu_control = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        dec_o.arithm_log  = !f3[2];
        // Taken is Zero for beq/bge/bgeu and !Zero for bne/blt/bltu.
        dec_o.br_invert   = f3[2] ^ f3[0];
      end
      OP_JAL: begin
        dec_o.legal      = 1'b1;
        dec_o.cls        = CLS_JAL;
        dec_o.imm_src    = IMM_J;
        dec_o.result_src = RES_PC4;
      end
      OP_LUI: begin
        dec_o.legal         = 1'b1;
        dec_o.cls           = CLS_LUI;
        dec_o.imm_src       = IMM_U;
        dec_o.reg_write_src = RWS_IMM;
      end
      OP_AUIPC: begin
        dec_o.legal         = 1'b1;
        dec_o.cls           = CLS_AUIPC;
        dec_o.imm_src       = IMM_U;
        dec_o.reg_write_src = RWS_PCIMM;
      end
      OP_SYSTEM: begin
        dec_o.legal      = (f3 == 3'b001);
        dec_o.cls        = CLS_CSR;
        dec_o.imm_src    = IMM_I;
        dec_o.result_src = RES_CSR;
      end
      default: dec_o.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I sequencer: FSM, sticky illegal flag and post-reset fetch hold.
// Handshake: a transfer happens in the cycle where req and ready are both high; req holds until then.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned RESET_PC_HOLD = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        IRWrite,
  output logic        PCEn,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  RegWriteSrc,
  output logic [2:0]  ImmSrc,
  output logic [3:0]  ALUControl,
  output logic        ArithmLog,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        CSRWrite,
  output logic        illegal,
  output state_t      state_dbg_o
);

  localparam logic [3:0] HOLD_INIT = 4'(RESET_PC_HOLD);

  state_t     state_q;
  logic       illegal_q;
  logic [3:0] hold_q;
  dec_t       dec;
  logic       run;

  ctrl_decode u_decode (
    .instr_i (Instr),
    .dec_o   (dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      hold_q    <= HOLD_INIT;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (hold_q != 4'd0) hold_q <= hold_q - 4'd1;
          else if (imem_ready) state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (dec.legal) state_q <= S_EXEC;
          else begin
            state_q   <= S_TRAP;
            illegal_q <= 1'b1;
          end
        end
        S_EXEC: begin
          case (dec.cls)
            CLS_LOAD, CLS_STORE: state_q <= S_MEM;
            CLS_BRANCH:          state_q <= S_FETCH;
            default:             state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ready) state_q <= (dec.cls == CLS_STORE) ? S_FETCH : S_WB;
        end
        S_WB:    state_q <= S_FETCH;
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Every strobe is masked while reset is high, so an abandoned operation never commits.
  assign run      = !reset;
  assign imem_req = run && (state_q == S_FETCH) && (hold_q == 4'd0);
  assign IRWrite  = imem_req && imem_ready;
  assign dmem_req = run && (state_q == S_MEM);
  assign dmem_we  = dmem_req && (dec.cls == CLS_STORE);
  assign PCEn     = run && (((state_q == S_EXEC) && (dec.cls == CLS_BRANCH)) ||
                            ((state_q == S_MEM) && dmem_ready && (dec.cls == CLS_STORE)) ||
                            (state_q == S_WB));
  assign RegWrite = run && (state_q == S_WB);
  assign CSRWrite = RegWrite && (dec.cls == CLS_CSR);

  assign ResultSrc   = dec.result_src;
  assign RegWriteSrc = dec.reg_write_src;
  assign ImmSrc      = dec.imm_src;
  assign ALUControl  = dec.alu_control;
  assign ArithmLog   = dec.arithm_log;
  assign ALUSrc      = dec.alu_src;
  assign PCSrc       = (dec.cls == CLS_BRANCH) ? (Zero ^ dec.br_invert) : (dec.cls == CLS_JAL);

  assign illegal     = illegal_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expectations queued and checked at retire.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Instr = 32'h0;
  logic        Zero = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, dmem_req, dmem_we, IRWrite, PCEn;
  logic [1:0]  ResultSrc, RegWriteSrc;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic        ArithmLog, PCSrc, ALUSrc, RegWrite, CSRWrite, illegal;
  state_t      state_dbg;

  multicycle_ctrl #(.RESET_PC_HOLD(HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .Instr       (Instr),
    .Zero        (Zero),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ready  (dmem_ready),
    .IRWrite     (IRWrite),
    .PCEn        (PCEn),
    .ResultSrc   (ResultSrc),
    .RegWriteSrc (RegWriteSrc),
    .ImmSrc      (ImmSrc),
    .ALUControl  (ALUControl),
    .ArithmLog   (ArithmLog),
    .PCSrc       (PCSrc),
    .ALUSrc      (ALUSrc),
    .RegWrite    (RegWrite),
    .CSRWrite    (CSRWrite),
    .illegal     (illegal),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference table ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [3:0]  base;
    logic        mem;
    logic        tz;
    logic        tn;
    logic [1:0]  res;
    logic [1:0]  rws;
    logic        chk_alu;
    logic [3:0]  aluc;
    logic        alusrc;
    logic        arith;
    logic        chk_imm;
    logic [2:0]  imm;
    logic        regw;
    logic        csrw;
    logic        we;
  } ins_t;

  typedef struct packed {
    logic [7:0] cycles;
    logic [7:0] ireq;
    logic [7:0] dreq;
    logic       pcsrc;
    logic [1:0] res;
    logic [1:0] rws;
    logic       chk_alu;
    logic [3:0] aluc;
    logic       alusrc;
    logic       arith;
    logic       chk_imm;
    logic [2:0] imm;
    logic       regw;
    logic       csrw;
    logic       we;
  } exp_t;

  localparam int I_ADD = 0, I_SUB = 1, I_ADDI = 2, I_SRAI = 3, I_XOR = 4, I_SLTU = 5;
  localparam int I_LW = 6, I_SW = 7, I_BNE = 8, I_BEQ = 9, I_BLT = 10, I_BGEU = 11;
  localparam int I_JAL = 12, I_LUI = 13, I_AUIPC = 14, I_CSR = 15;

  ins_t tbl [16];
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  state_t st_log [8];
  int   obs_regw_cyc;
  int   obs_csrw_cyc;

  initial begin
    tbl[I_ADD]   = '{32'h002081B3, 4'd4, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[I_SUB]   = '{32'h407302B3, 4'd4, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[I_ADDI]  = '{32'h00500093, 4'd4, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[I_SRAI]  = '{32'h4030D113, 4'd4, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[I_XOR]   = '{32'h0020C233, 4'd4, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[I_SLTU]  = '{32'h0020B233, 4'd4, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[I_LW]    = '{32'h0080A283, 4'd5, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[I_SW]    = '{32'h0050A623, 4'd4, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1};
    tbl[I_BNE]   = '{32'h00209463, 4'd3, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0};
    tbl[I_BEQ]   = '{32'h00208463, 4'd3, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0};
    tbl[I_BLT]   = '{32'h0020C463, 4'd3, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0};
    tbl[I_BGEU]  = '{32'h0020F463, 4'd3, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0};
    tbl[I_JAL]   = '{32'h010000EF, 4'd4, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 3'b011, 1'b1, 1'b0, 1'b0};
    tbl[I_LUI]   = '{32'h123452B7, 4'd4, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0, 1'b0};
    tbl[I_AUIPC] = '{32'h00001317, 4'd4, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0, 1'b0};
    tbl[I_CSR]   = '{32'h30009073, 4'd4, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0};
  end

  // ---------------- driver tasks ----------------
  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic do_reset();
    reset = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({imem_req, IRWrite, dmem_req, PCEn, RegWrite, CSRWrite} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_strobes got %b exp 000000", {imem_req, IRWrite, dmem_req, PCEn, RegWrite, CSRWrite});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    dmem_ready = 1'b0;
    for (int h = 0; h < HOLD; h++) begin
      @(negedge clk);
      n_tests++;
      if ({state_dbg, imem_req, IRWrite, illegal, PCEn} !== {S_FETCH, 4'b0000}) begin
        n_fail++;
        $display("FAIL reset_hold[%0d] got state=%0d req=%b irw=%b ill=%b pcen=%b exp state=0 all 0",
                 h, state_dbg, imem_req, IRWrite, illegal, PCEn);
      end
      @(posedge clk); #1;
    end
    imem_ready = 1'b0;
  endtask

  task automatic run_instr(input int idx, input int iw, input int dw, input logic z, input bit noise);
    exp_t e, g;
    int cyc = 0, ic = 0, dc = 0, regw_cnt = 0, csrw_cnt = 0;
    bit done = 0, have_snap = 0, held_ok = 1;
    logic we_seen = 1'b0;
    logic [13:0] snap = '0, now;
    logic o_pcsrc = 1'b0, o_alusrc = 1'b0, o_arith = 1'b0;
    logic [1:0] o_res = '0, o_rws = '0;
    logic [3:0] o_aluc = '0;
    logic [2:0] o_imm = '0;

    e = '0;
    e.cycles  = 8'(int'(tbl[idx].base) + iw + (tbl[idx].mem ? dw : 0));
    e.ireq    = 8'(iw + 1);
    e.dreq    = tbl[idx].mem ? 8'(dw + 1) : 8'd0;
    e.pcsrc   = z ? tbl[idx].tz : tbl[idx].tn;
    e.res     = tbl[idx].res;
    e.rws     = tbl[idx].rws;
    e.chk_alu = tbl[idx].chk_alu;
    e.aluc    = tbl[idx].aluc;
    e.alusrc  = tbl[idx].alusrc;
    e.arith   = tbl[idx].arith;
    e.chk_imm = tbl[idx].chk_imm;
    e.imm     = tbl[idx].imm;
    e.regw    = tbl[idx].regw;
    e.csrw    = tbl[idx].csrw;
    e.we      = tbl[idx].we;
    exp_q.push_back(e);

    Instr = tbl[idx].instr;
    Zero  = z;
    obs_regw_cyc = 0;
    obs_csrw_cyc = 0;
    for (int k = 0; k < 8; k++) st_log[k] = S_TRAP;
    while (!done && cyc < 40) begin
      cyc++;
      imem_ready = imem_req ? (ic >= iw) : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      dmem_ready = dmem_req ? (dc >= dw) : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      @(negedge clk);
      if (cyc <= 8) st_log[cyc-1] = state_dbg;
      if (imem_req) ic++;
      if (dmem_req) begin
        dc++;
        if (dmem_we) we_seen = 1'b1;
      end
      if (RegWrite) begin regw_cnt++; obs_regw_cyc = cyc; end
      if (CSRWrite) begin csrw_cnt++; obs_csrw_cyc = cyc; end
      now = {ResultSrc, RegWriteSrc, ImmSrc, ALUControl, ArithmLog, ALUSrc, PCSrc};
      if (state_dbg == S_DECODE) begin snap = now; have_snap = 1; end
      else if (have_snap && now !== snap) held_ok = 0;
      if (PCEn) begin
        done = 1;
        o_pcsrc = PCSrc; o_res = ResultSrc; o_rws = RegWriteSrc; o_aluc = ALUControl;
        o_alusrc = ALUSrc; o_arith = ArithmLog; o_imm = ImmSrc;
      end
      @(posedge clk); #1;
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;

    // ---------------- scoreboard pop / compare ----------------
    g = exp_q.pop_front();
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL retire_timeout[%0d] no PCEn within 40 cycles", idx); end
    n_tests++;
    if (8'(cyc) !== g.cycles) begin n_fail++; $display("FAIL cycles[%0d] got %0d exp %0d", idx, cyc, g.cycles); end
    n_tests++;
    if (8'(ic) !== g.ireq) begin n_fail++; $display("FAIL imem_req_cycles[%0d] got %0d exp %0d", idx, ic, g.ireq); end
    n_tests++;
    if (8'(dc) !== g.dreq) begin n_fail++; $display("FAIL dmem_req_cycles[%0d] got %0d exp %0d", idx, dc, g.dreq); end
    n_tests++;
    if (o_pcsrc !== g.pcsrc) begin n_fail++; $display("FAIL pcsrc[%0d] got %b exp %b", idx, o_pcsrc, g.pcsrc); end
    n_tests++;
    if (o_res !== g.res) begin n_fail++; $display("FAIL resultsrc[%0d] got %b exp %b", idx, o_res, g.res); end
    n_tests++;
    if (o_rws !== g.rws) begin n_fail++; $display("FAIL regwritesrc[%0d] got %b exp %b", idx, o_rws, g.rws); end
    n_tests++;
    if (regw_cnt !== int'(g.regw)) begin n_fail++; $display("FAIL regwrite_count[%0d] got %0d exp %0d", idx, regw_cnt, g.regw); end
    n_tests++;
    if (csrw_cnt !== int'(g.csrw)) begin n_fail++; $display("FAIL csrwrite_count[%0d] got %0d exp %0d", idx, csrw_cnt, g.csrw); end
    n_tests++;
    if (we_seen !== g.we) begin n_fail++; $display("FAIL dmem_we[%0d] got %b exp %b", idx, we_seen, g.we); end
    n_tests++;
    if (held_ok !== 1'b1) begin n_fail++; $display("FAIL selects_held[%0d] got changed exp constant", idx); end
    n_tests++;
    if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_legal[%0d] got %b exp 0", idx, illegal); end
    if (g.chk_alu) begin
      n_tests++;
      if ({o_aluc, o_alusrc, o_arith} !== {g.aluc, g.alusrc, g.arith}) begin
        n_fail++;
        $display("FAIL alu[%0d] got aluc=%b src=%b ar=%b exp aluc=%b src=%b ar=%b",
                 idx, o_aluc, o_alusrc, o_arith, g.aluc, g.alusrc, g.arith);
      end
    end
    if (g.chk_imm) begin
      n_tests++;
      if (o_imm !== g.imm) begin n_fail++; $display("FAIL immsrc[%0d] got %b exp %b", idx, o_imm, g.imm); end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_tests++;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_after_hold got %b exp 1", imem_req); end
  endtask

  task automatic test_add();
    state_t exp_st [4] = '{S_FETCH, S_DECODE, S_EXEC, S_WB};
    run_instr(I_ADD, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (st_log[k] !== exp_st[k]) begin n_fail++; $display("FAIL add_state[%0d] got %0d exp %0d", k, st_log[k], exp_st[k]); end
    end
    n_tests++;
    if (obs_regw_cyc !== 4) begin n_fail++; $display("FAIL add_regwrite_cycle got %0d exp 4", obs_regw_cyc); end
  endtask

  task automatic test_lw_stall();
    run_instr(I_LW, 0, 3, 1'b0, 1'b0);
    n_tests++;
    if ({st_log[3], st_log[6], st_log[7]} !== {S_MEM, S_MEM, S_WB}) begin
      n_fail++;
      $display("FAIL lw_states got %0d,%0d,%0d exp 3,3,4", st_log[3], st_log[6], st_log[7]);
    end
    run_instr(I_SW, 1, 2, 1'b0, 1'b0);
  endtask

  task automatic test_branch();
    run_instr(I_BNE, 0, 0, 1'b1, 1'b0);
    n_tests++;
    if (st_log[2] !== S_EXEC) begin n_fail++; $display("FAIL bne_pcen_state got %0d exp 2", st_log[2]); end
    run_instr(I_BNE, 0, 0, 1'b0, 1'b0);
    run_instr(I_BEQ, 0, 0, 1'b1, 1'b0);
    run_instr(I_BLT, 1, 0, 1'b0, 1'b0);
    run_instr(I_BGEU, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_illegal(input logic [31:0] ins);
    int req_after = 0, pcen_cnt = 0, regw_cnt = 0;
    Instr = ins;
    Zero = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      imem_ready = (c == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (c > 1 && imem_req) req_after++;
      if (PCEn) pcen_cnt++;
      if (RegWrite || CSRWrite) regw_cnt++;
      if (c == 3) begin
        n_tests++;
        if ({state_dbg, illegal} !== {S_TRAP, 1'b1}) begin
          n_fail++;
          $display("FAIL trap_entry[%h] got state=%0d ill=%b exp state=5 ill=1", ins, state_dbg, illegal);
        end
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if ({req_after, pcen_cnt, regw_cnt} !== {32'd0, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL trap_quiet[%h] got req=%0d pcen=%0d regw=%0d exp 0", ins, req_after, pcen_cnt, regw_cnt);
    end
    n_tests++;
    if (illegal !== 1'b1) begin n_fail++; $display("FAIL trap_sticky[%h] got %b exp 1", ins, illegal); end
    do_reset();
    run_instr(I_ADDI, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit in_mem = 0;
    Instr = tbl[I_LW].instr;
    for (int c = 0; c < 10 && !in_mem; c++) begin
      imem_ready = imem_req;
      dmem_ready = 1'b0;
      @(negedge clk);
      if (state_dbg == S_MEM && dmem_req) in_mem = 1;
      @(posedge clk); #1;
    end
    n_tests++;
    if (!in_mem) begin n_fail++; $display("FAIL reset_mid_reach got no MEM exp MEM with dmem_req"); end
    do_reset();
    run_instr(I_SUB, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_csrrw();
    run_instr(I_CSR, 1, 0, 1'b0, 1'b0);
    n_tests++;
    if (obs_csrw_cyc !== 5) begin n_fail++; $display("FAIL csrw_cycle got %0d exp 5", obs_csrw_cyc); end
    run_instr(I_JAL, 0, 0, 1'b0, 1'b0);
    run_instr(I_LUI, 0, 0, 1'b0, 1'b0);
    run_instr(I_AUIPC, 2, 0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 24; n++) begin
      run_instr($urandom_range(0, 15), $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'b1);
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_lw_stall();
    test_branch();
    test_csrrw();
    test_illegal(32'h000080E7);
    test_illegal(32'h022081B3);
    test_reset_mid();
    test_back_to_back();
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle sequencing controller for the RV32I datapath. It steps each instruction through fetch, decode, execute, memory and writeback states, and it drives every datapath control input. It also produces PC and instruction-register enables and handshakes with instruction and data memories that may stall. It sits between the memories and the datapath, so memory latency is no longer tied to a single cycle.

## Interface
Parameters:
- RESET_PC_HOLD, 0: number of extra FETCH-idle cycles after reset release (0..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- Instr  in  32  instruction-register output (stable from DECODE through WB).
- Zero  in  1  ALU zero flag.
- imem_req / imem_ready  out / in  1 / 1  instruction fetch handshake.
- dmem_req / dmem_we / dmem_ready  out / out / in  1 / 1 / 1  data access handshake.
- IRWrite, PCEn  out  1  instruction-register load strobe and PC register enable.
- ResultSrc  out  2  00 ALU, 01 ReadData, 10 PC+4, 11 CSR.
- RegWriteSrc  out  2  00 Result, 01 ImmExt (lui), 10 PC+Imm (auipc).
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 shift-right.
- ArithmLog  out  1  1 = arithmetic (sub / sra).
- PCSrc, ALUSrc, RegWrite, CSRWrite  out  1  datapath controls.
- illegal  out  1  sticky trap flag.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Strobes are asserted only in the states listed below. The strobes are IRWrite, PCEn, RegWrite, CSRWrite, imem_req and dmem_req.
- Selects are decoded combinationally from Instr and are held constant from DECODE through WB. The selects are ResultSrc, RegWriteSrc, ImmSrc, ALUControl, ArithmLog, ALUSrc and PCSrc.
- FETCH:
  - imem_req=1 until imem_ready.
  - The cycle imem_ready=1: IRWrite=1, next state DECODE.
- DECODE:
  - Legal instruction: next state EXEC.
  - Illegal instruction: next state TRAP.
  - Legal set: R/I-ALU, lw, sw, beq/bne/blt/bge/bltu/bgeu, jal, lui, auipc, csrrw.
  - Every other encoding is illegal, including jalr.
- EXEC, by instruction class:
  - Load/store: next state MEM.
  - Branch: PCEn=1, PCSrc=taken, next state FETCH.
  - All others: next state WB.
- Branch ALU operation and taken condition:
  - beq: sub, taken=Zero.
  - bne: sub, taken=!Zero.
  - blt: slt, taken=!Zero.
  - bge: slt, taken=Zero.
  - bltu/bgeu: same as blt/bge using sltu.
- MEM:
  - dmem_req=1 and dmem_we=(sw), held until dmem_ready.
  - On dmem_ready, store: PCEn=1, next state FETCH.
  - On dmem_ready, load: next state WB.
- WB: RegWrite=1, PCEn=1, next state FETCH.
- WB per instruction:
  - jal: ResultSrc=10, PCSrc=1.
  - csrrw: CSRWrite=1, ResultSrc=11.
  - lui: RegWriteSrc=01.
  - auipc: RegWriteSrc=10.
  - lw: ResultSrc=01.
- TRAP: illegal=1, all strobes 0. TRAP is held until reset.

## Timing
- Reset:
  - Next state FETCH; illegal=0.
  - All strobes are 0 during reset.
  - After reset release, imem_req stays low for RESET_PC_HOLD cycles.
- Reset mid-operation (any state, any pending handshake): the operation is abandoned. No PCEn, RegWrite or CSRWrite is issued.
- Minimum cycle counts, with ready asserted in the same cycle as req:
  - branch 3.
  - ALU/lui/auipc/jal/csrrw 4.
  - sw 4.
  - lw 5.
- Each wait cycle on imem_ready or dmem_ready adds one cycle. During a wait, req stays high and all other outputs are unchanged.
- Exactly one PCEn pulse per retired instruction. Zero PCEn pulses for a trapped instruction.
- A ready input outside its own request state is ignored.

## Structure
- Package ctrl_pkg holds:
  - state_t enum.
  - Opcode constants.
  - ALUControl, ResultSrc, RegWriteSrc and ImmSrc encodings.
- Sub-module ctrl_decode: purely combinational. It maps Instr to the selects plus {class, legal}.
- The top level contains the FSM, the sticky illegal register and the reset hold counter.

## Test plan
- add x3,x1,x2 (0x002081B3), imem_ready tied 1:
  - states FETCH-DECODE-EXEC-WB.
  - ALUControl=0000, ALUSrc=0, RegWrite=1 only in cycle 4, single PCEn pulse.
- lw with dmem_ready delayed 3 cycles:
  - dmem_req high for 4 cycles, dmem_we=0.
  - ResultSrc=01 in WB, total 8 cycles.
- bne with Zero=1: PCSrc=0, PCEn in EXEC. Same with Zero=0: PCSrc=1, no RegWrite.
- jalr (0x000080E7):
  - TRAP reached after DECODE, illegal=1.
  - No further imem_req until reset.
  - reset clears illegal and restarts FETCH.
- reset asserted during MEM with dmem_req high:
  - next cycle FETCH.
  - dmem_req=0, no RegWrite/PCEn issued.
- csrrw (0x30009073): CSRWrite=1 and ResultSrc=11 in WB only.
